// File: rtl/park_slot_arbiter.sv
// park_slot_arbiter: two-gate car park slot allocator with six slots (A1..A3, B1..B3).
// Optional build macro PARK_RR_EN selects round-robin arbitration between the two
// gates on contention; when undefined, gate 0 has fixed priority.
module park_slot_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] pref,
    input  logic       rel_valid,
    input  logic [2:0] rel_num,
    output logic [1:0] gnt,
    output logic [2:0] gnt_num,
    output logic [1:0] deny,
    output logic [5:0] occ,
    output logic [2:0] free_cnt,
    output logic       full
);

    typedef enum logic [1:0] {
        StIdle,
        StAlloc,
        StWaitDrop
    } state_e;

    state_e     state_q, state_d;
    logic       win_q, win_d;
    logic       pref_q, pref_d;
    logic [5:0] occ_q, occ_d;
    logic [2:0] free_cnt_q, free_cnt_d;
    logic       full_q, full_d;
    logic [1:0] gnt_q, gnt_d;
    logic [2:0] gnt_num_q, gnt_num_d;
    logic [1:0] deny_q, deny_d;

`ifdef PARK_RR_EN
    // Last served requester; reset value 1 makes requester 0 win the first contention.
    logic       last_q, last_d;
`endif

    logic       arb_win;
    logic [2:0] pref_free;
    logic [2:0] alt_free;
    logic [2:0] alloc_code;
    logic       alloc_ok;
    logic [5:0] rel_mask;

    // Slot code to occupancy bit; codes 000 and 100 map to nothing.
    function automatic logic [5:0] code_to_mask(input logic [2:0] code);
        logic [5:0] m;
        m = 6'b000000;
        case (code)
            3'b001:  m = 6'b000001;
            3'b010:  m = 6'b000010;
            3'b011:  m = 6'b000100;
            3'b101:  m = 6'b001000;
            3'b110:  m = 6'b010000;
            3'b111:  m = 6'b100000;
            default: m = 6'b000000;
        endcase
        return m;
    endfunction

    // Position code (1..3) of the lowest set bit in a zone's free vector, 0 if none.
    function automatic logic [1:0] lowest_pos(input logic [2:0] v);
        logic [1:0] p;
        if (v[0])      p = 2'd1;
        else if (v[1]) p = 2'd2;
        else if (v[2]) p = 2'd3;
        else           p = 2'd0;
        return p;
    endfunction

    // Winner selection for a request seen in idle.
    always_comb begin
`ifdef PARK_RR_EN
        if (req == 2'b11) arb_win = ~last_q;
        else              arb_win = ~req[0];
`else
        arb_win = ~req[0];
`endif
    end

    // Slot choice: preferred zone first, then the other zone, both from pre-edge occupancy.
    always_comb begin
        pref_free = pref_q ? ~occ_q[5:3] : ~occ_q[2:0];
        alt_free  = pref_q ? ~occ_q[2:0] : ~occ_q[5:3];
        if (|pref_free)     alloc_code = {pref_q, lowest_pos(pref_free)};
        else if (|alt_free) alloc_code = {~pref_q, lowest_pos(alt_free)};
        else                alloc_code = 3'b000;
        alloc_ok = |alloc_code[1:0];
        rel_mask = rel_valid ? code_to_mask(rel_num) : 6'b000000;
    end

    // Next-state, occupancy update and registered pulse outputs.
    always_comb begin
        state_d   = state_q;
        win_d     = win_q;
        pref_d    = pref_q;
        gnt_d     = 2'b00;
        deny_d    = 2'b00;
        gnt_num_d = 3'b000;
`ifdef PARK_RR_EN
        last_d    = last_q;
`endif
        // Release clears first so a simultaneous allocation's set always survives.
        occ_d     = occ_q & ~rel_mask;

        case (state_q)
            StIdle: begin
                if (|req) begin
                    win_d   = arb_win;
                    pref_d  = pref[arb_win];
                    state_d = StAlloc;
                end
            end
            StAlloc: begin
                if (alloc_ok) begin
                    occ_d        = occ_d | code_to_mask(alloc_code);
                    gnt_d[win_q] = 1'b1;
                    gnt_num_d    = alloc_code;
                end else begin
                    deny_d[win_q] = 1'b1;
                end
`ifdef PARK_RR_EN
                last_d  = win_q;
`endif
                state_d = StWaitDrop;
            end
            StWaitDrop: begin
                if (!req[win_q]) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Free count and full flag derived from the next occupancy so they register alongside it.
    always_comb begin
        logic [2:0] used;
        used = 3'd0;
        for (int i = 0; i < 6; i++) begin
            used = used + {2'b00, occ_d[i]};
        end
        free_cnt_d = 3'd6 - used;
        full_d     = &occ_d;
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            win_q      <= 1'b0;
            pref_q     <= 1'b0;
            occ_q      <= 6'b000000;
            free_cnt_q <= 3'd6;
            full_q     <= 1'b0;
            gnt_q      <= 2'b00;
            gnt_num_q  <= 3'b000;
            deny_q     <= 2'b00;
`ifdef PARK_RR_EN
            last_q     <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            pref_q     <= pref_d;
            occ_q      <= occ_d;
            free_cnt_q <= free_cnt_d;
            full_q     <= full_d;
            gnt_q      <= gnt_d;
            gnt_num_q  <= gnt_num_d;
            deny_q     <= deny_d;
`ifdef PARK_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign gnt_num  = gnt_num_q;
    assign deny     = deny_q;
    assign occ      = occ_q;
    assign free_cnt = free_cnt_q;
    assign full     = full_q;

endmodule

// File: tb/tb_park_slot_arbiter.sv
// Bench for park_slot_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a slot-list model of the car park.
module tb_park_slot_arbiter;

`ifdef PARK_RR_EN
    localparam bit RrEn = 1'b1;
`else
    localparam bit RrEn = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] pref = 2'b00;
    logic       rel_valid = 1'b0;
    logic [2:0] rel_num = 3'b000;
    logic [1:0] gnt;
    logic [2:0] gnt_num;
    logic [1:0] deny;
    logic [5:0] occ;
    logic [2:0] free_cnt;
    logic       full;

    int n_cmp = 0;
    int n_bad = 0;

    park_slot_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .pref     (pref),
        .rel_valid(rel_valid),
        .rel_num  (rel_num),
        .gnt      (gnt),
        .gnt_num  (gnt_num),
        .deny     (deny),
        .occ      (occ),
        .free_cnt (free_cnt),
        .full     (full)
    );

    always #5 clk = ~clk;

    // Model: each slot 0..5 (A1..A3, B1..B3) is simply taken or not.
    int         m_taken[6];
    int         m_phase;   // 0 waiting for a request, 1 request accepted, 2 waiting for drop
    int         m_win;
    int         m_pref;
    int         m_last;
    logic [1:0] m_gnt;
    logic [1:0] m_deny;
    logic [2:0] m_num;

    function automatic int slot_of(input logic [2:0] code);
        if (code[1:0] == 2'b00) return -1;
        return int'(code[2]) * 3 + int'(code[1:0]) - 1;
    endfunction

    function automatic logic [2:0] code_of(input int s);
        logic [2:0] c;
        c[2]   = (s >= 3);
        c[1:0] = 2'((s % 3) + 1);
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_taken[i] = 0;
        m_phase = 0;
        m_win   = 0;
        m_pref  = 0;
        m_last  = 1;
        m_gnt   = 2'b00;
        m_deny  = 2'b00;
        m_num   = 3'b000;
    endtask

    task automatic model_step();
        int pick;
        int old_phase;
        int s;
        if (rst) begin
            model_reset();
            return;
        end
        pick      = -1;
        old_phase = m_phase;
        m_gnt     = 2'b00;
        m_deny    = 2'b00;
        m_num     = 3'b000;
        if (old_phase == 1) begin
            for (int k = 0; k < 3; k++)
                if (pick < 0 && m_taken[m_pref * 3 + k] == 0) pick = m_pref * 3 + k;
            for (int k = 0; k < 3; k++)
                if (pick < 0 && m_taken[(1 - m_pref) * 3 + k] == 0) pick = (1 - m_pref) * 3 + k;
            if (pick >= 0) begin
                m_gnt[m_win] = 1'b1;
                m_num        = code_of(pick);
            end else begin
                m_deny[m_win] = 1'b1;
            end
            m_last = m_win;
        end
        if (rel_valid) begin
            s = slot_of(rel_num);
            if (s >= 0) m_taken[s] = 0;
        end
        if (pick >= 0) m_taken[pick] = 1;
        case (old_phase)
            0: if (req != 2'b00) begin
                if (req == 2'b11) m_win = RrEn ? 1 - m_last : 0;
                else              m_win = req[1] ? 1 : 0;
                m_pref  = int'(pref[m_win]);
                m_phase = 1;
            end
            1: m_phase = 2;
            default: if (req[m_win] == 1'b0) m_phase = 0;
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        logic [5:0] e_occ;
        int         e_free;
        for (int i = 0; i < 6; i++) e_occ[i] = (m_taken[i] != 0);
        e_free = 0;
        for (int i = 0; i < 6; i++) if (m_taken[i] == 0) e_free++;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("deny", 32'(deny), 32'(m_deny));
        chk("gnt_num", 32'(gnt_num), 32'(m_num));
        chk("occ", 32'(occ), 32'(e_occ));
        chk("free_cnt", 32'(free_cnt), 32'(e_free));
        chk("full", 32'(full), 32'(e_free == 0));
    endtask

    // One clock: model follows the edge, DUT is compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic serve(input int r, input bit p);
        req     = 2'b00;
        req[r]  = 1'b1;
        pref[r] = p;
        tick();
        tick();
        req = 2'b00;
        tick();
        tick();
    endtask

    initial begin
        bit         got;
        int         w;
        bit [1:0]   done;
        int         exp_seq[3];

        model_reset();
        tick();
        tick();
        chk("reset_occ", 32'(occ), 32'h0);
        chk("reset_free", 32'(free_cnt), 32'd6);
        chk("reset_full", 32'(full), 32'd0);
        chk("reset_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;

        // First grant: A1 two edges after request.
        req  = 2'b01;
        pref = 2'b00;
        tick();
        chk("early_gnt", 32'(gnt), 32'd0);
        tick();
        chk("first_gnt", 32'(gnt), 32'b01);
        chk("first_num", 32'(gnt_num), 32'b001);
        chk("first_occ", 32'(occ), 32'b000001);
        chk("first_free", 32'(free_cnt), 32'd5);
        req = 2'b00;
        tick();
        chk("gnt_one_cycle", 32'(gnt), 32'd0);
        tick();

        // Zone A fills, requester 1 falls back to B1.
        serve(0, 1'b0);
        serve(0, 1'b0);
        req  = 2'b10;
        pref = 2'b00;
        tick();
        tick();
        chk("fallback_gnt", 32'(gnt), 32'b10);
        chk("fallback_num", 32'(gnt_num), 32'b101);
        chk("fallback_occ", 32'(occ), 32'b001111);
        req = 2'b00;
        tick();
        tick();

        // Fill the park, then a denied request.
        serve(1, 1'b1);
        serve(1, 1'b1);
        chk("full_set", 32'(full), 32'd1);
        req = 2'b01;
        tick();
        tick();
        chk("deny_pulse", 32'(deny), 32'b01);
        chk("deny_no_gnt", 32'(gnt), 32'd0);
        chk("deny_full", 32'(full), 32'd1);
        chk("deny_free", 32'(free_cnt), 32'd0);
        req = 2'b00;
        tick();
        chk("deny_one_cycle", 32'(deny), 32'd0);
        tick();

        // Release of B2 on the allocating edge: allocation still sees a full park.
        req = 2'b01;
        tick();
        rel_valid = 1'b1;
        rel_num   = 3'b110;
        tick();
        chk("relalloc_deny", 32'(deny), 32'b01);
        chk("relalloc_occ", 32'(occ), 32'b101111);
        chk("relalloc_free", 32'(free_cnt), 32'd1);
        rel_num = 3'b100;
        req     = 2'b00;
        tick();
        chk("rel_invalid_occ", 32'(occ), 32'b101111);
        rel_valid = 1'b0;
        tick();

        // Reset while an allocation is pending.
        req = 2'b01;
        tick();
        rst = 1'b1;
        #1;
        model_reset();
        chk("async_rst_occ", 32'(occ), 32'h0);
        chk("async_rst_free", 32'(free_cnt), 32'd6);
        tick();
        chk("rst_no_gnt", 32'(gnt), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        chk("post_rst_gnt", 32'(gnt), 32'b01);
        chk("post_rst_num", 32'(gnt_num), 32'b001);
        req = 2'b00;
        tick();
        tick();

        // Contention order with both requests held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        exp_seq[0] = 0;
        exp_seq[1] = RrEn ? 1 : 0;
        exp_seq[2] = 0;
        for (int rnd = 0; rnd < 3; rnd++) begin
            got = 1'b0;
            for (int k = 0; k < 8 && !got; k++) begin
                tick();
                if (gnt != 2'b00) got = 1'b1;
            end
            chk("contention_gnt_seen", 32'(got), 32'd1);
            if (got) begin
                w = gnt[1] ? 1 : 0;
                chk("contention_winner", 32'(w), 32'(exp_seq[rnd]));
                req[w] = 1'b0;
                tick();
                req[w] = 1'b1;
            end
        end
        req = 2'b00;
        tick();
        tick();

        // Random traffic.
        done = 2'b00;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            for (int r = 0; r < 2; r++) begin
                if (m_gnt[r] || m_deny[r]) done[r] = 1'b1;
                if (req[r] && done[r]) begin
                    if ($urandom_range(1, 0) == 0) begin
                        req[r]  = 1'b0;
                        done[r] = 1'b0;
                    end
                end else if (!req[r] && $urandom_range(2, 0) == 0) begin
                    req[r] = 1'b1;
                end
            end
            pref      = 2'($urandom);
            rel_valid = ($urandom_range(3, 0) == 0);
            rel_num   = 3'($urandom);
            if (rst) begin
                rst = 1'b0;
            end else if ($urandom_range(399, 0) == 0) begin
                rst = 1'b1;
                model_reset();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
